// File: rtl/avmm_arb_pkg.sv
// Shared types and helpers for the Avalon-MM round-robin arbiter.
package avmm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } arb_state_t;

  // Width of an index into n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: the first requester after last_grant wins.
module rr_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  input  logic               valid,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_any
);

  int idx;

  // Scan from farthest to nearest so the nearest requester overwrites the pick
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (valid) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = (int'(last_grant) + k) % NUM_REQ;
        if (req[idx[IW-1:0]]) begin
          gnt_idx = idx[IW-1:0];
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/avmm_rr_arbiter.sv
// Round-robin share of one fixed-latency Avalon-MM slave between NUM_REQ masters,
// with one transaction outstanding at a time.
module avmm_rr_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0][ADDRESSWIDTH-1:0]    m_address,
  input  logic [NUM_REQ-1:0]                      m_read,
  input  logic [NUM_REQ-1:0]                      m_write,
  input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]       m_writedata,
  input  logic [NUM_REQ-1:0][DATAWIDTH/8-1:0]     m_byteenable,
  output logic [NUM_REQ-1:0]                      m_waitrequest,
  output logic [NUM_REQ-1:0][DATAWIDTH-1:0]       m_readdata,
  output logic [NUM_REQ-1:0]                      m_readdatavalid,
  output logic [ADDRESSWIDTH-1:0]                 avm_address,
  output logic                                    avm_read,
  output logic                                    avm_write,
  output logic [DATAWIDTH-1:0]                    avm_writedata,
  output logic [DATAWIDTH/8-1:0]                  avm_byteenable,
  input  logic [DATAWIDTH-1:0]                    avm_readdata
);

  localparam int IW = idx_width(NUM_REQ);

  arb_state_t         state, state_next;
  logic [IW-1:0]      grant_idx, last_grant, gnt_idx;
  logic               gnt_any, is_write;
  logic [2:0]         cnt;
  logic [NUM_REQ-1:0] req;

  assign req = m_read | m_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .valid      (state == IDLE),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The slave only sees a command during the single ISSUE cycle
  always_comb begin
    state_next     = state;
    m_waitrequest  = '1;
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    case (state)
      IDLE: if (gnt_any) state_next = ISSUE;
      ISSUE: begin
        m_waitrequest[grant_idx] = 1'b0;
        avm_address    = m_address[grant_idx];
        avm_writedata  = m_writedata[grant_idx];
        avm_byteenable = m_byteenable[grant_idx];
        avm_write      = m_write[grant_idx];
        avm_read       = m_read[grant_idx] & ~m_write[grant_idx];
        state_next     = is_write ? IDLE : RD_WAIT;
      end
      RD_WAIT: if (cnt == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx       <= '0;
      is_write        <= 1'b0;
      last_grant      <= IW'(NUM_REQ - 1);
      cnt             <= '0;
      m_readdata      <= '0;
      m_readdatavalid <= '0;
    end else begin
      m_readdatavalid <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          grant_idx <= gnt_idx;
          is_write  <= m_write[gnt_idx];
        end
        ISSUE: begin
          last_grant <= grant_idx;
          cnt        <= 3'(READ_LATENCY - 1);
        end
        RD_WAIT: begin
          if (cnt == 3'd0) begin
            m_readdata[grant_idx]      <= avm_readdata;
            m_readdatavalid[grant_idx] <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Bench for avmm_rr_arbiter: vector table plus hand sequences, read data scored via a queue.
module tb_avmm_rr_arbiter;

  typedef struct {
    int          mst;
    bit          rd;
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          mst;
    logic [31:0] data;
    int          due;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  sb_item_t sb_q[$];
  sb_item_t mon_item;

  logic [1:0][31:0] m_address, m_writedata, m_readdata;
  logic [1:0]       m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [1:0][3:0]  m_byteenable;
  logic [31:0]      avm_address, avm_writedata, avm_readdata;
  logic             avm_read, avm_write;
  logic [3:0]       avm_byteenable;

  logic [1:0][31:0] m3_address, m3_writedata, m3_readdata;
  logic [1:0]       m3_read, m3_write, m3_waitrequest, m3_readdatavalid;
  logic [1:0][3:0]  m3_byteenable;
  logic [31:0]      avm3_address, avm3_writedata, avm3_readdata;
  logic             avm3_read, avm3_write;
  logic [3:0]       avm3_byteenable;

  logic [31:0] mem  [32];
  logic [31:0] mem3 [32];
  logic [31:0] rd_pipe;
  logic [31:0] pipe3 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avmm_rr_arbiter #(.NUM_REQ(2), .DATAWIDTH(32), .ADDRESSWIDTH(32), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata)
  );

  avmm_rr_arbiter #(.NUM_REQ(2), .DATAWIDTH(32), .ADDRESSWIDTH(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .m_address(m3_address), .m_read(m3_read), .m_write(m3_write),
    .m_writedata(m3_writedata), .m_byteenable(m3_byteenable),
    .m_waitrequest(m3_waitrequest), .m_readdata(m3_readdata), .m_readdatavalid(m3_readdatavalid),
    .avm_address(avm3_address), .avm_read(avm3_read), .avm_write(avm3_write),
    .avm_writedata(avm3_writedata), .avm_byteenable(avm3_byteenable), .avm_readdata(avm3_readdata)
  );

  // Slave memories: registered read data, one stage for dut and three for dut3
  always @(posedge clk) begin
    rd_pipe  <= mem[avm_address[4:0]];
    pipe3[0] <= mem3[avm3_address[4:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    for (int b = 0; b < 4; b++) begin
      if (avm_write && avm_byteenable[b])   mem[avm_address[4:0]][b*8 +: 8]   <= avm_writedata[b*8 +: 8];
      if (avm3_write && avm3_byteenable[b]) mem3[avm3_address[4:0]][b*8 +: 8] <= avm3_writedata[b*8 +: 8];
    end
  end
  assign avm_readdata  = rd_pipe;
  assign avm3_readdata = pipe3[2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every readdatavalid pulse must match the oldest expected read
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_readdatavalid[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput($sformatf("unexpected valid m%0d", i), 32'(m_readdatavalid[i]), 32'd0);
        end else begin
          mon_item = sb_q.pop_front();
          checkOutput("rd master", 32'(i), 32'(mon_item.mst));
          checkOutput($sformatf("rd data m%0d", i), m_readdata[i], mon_item.data);
          checkOutput($sformatf("rd cycle m%0d", i), 32'(cyc), 32'(mon_item.due));
        end
      end
    end
  end

  task automatic waitDrain(input string name);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    checkOutput({name, " drain"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int start, acc;
    bit seen;
    @(posedge clk); #1;
    m_address[v.mst]    = {27'd0, v.addr};
    m_writedata[v.mst]  = v.wdata;
    m_byteenable[v.mst] = v.be;
    m_read[v.mst]       = v.rd;
    m_write[v.mst]      = v.wr;
    start = cyc;
    acc   = -1;
    if (v.rd && !v.wr) sb_q.push_back('{mst: v.mst, data: v.exp_rdata, due: start + 3});
    for (int k = 0; k < 10 && acc < 0; k++) begin
      @(negedge clk);
      if (!m_waitrequest[v.mst]) begin
        acc = cyc - start;
        checkOutput({name, " avm_write"}, 32'(avm_write), 32'(v.wr));
        checkOutput({name, " avm_read"}, 32'(avm_read), 32'(v.rd & ~v.wr));
        checkOutput({name, " avm_address"}, avm_address, {27'd0, v.addr});
        checkOutput({name, " other waitrequest"}, 32'(m_waitrequest[1 - v.mst]), 32'd1);
        if (v.wr) begin
          checkOutput({name, " avm_writedata"}, avm_writedata, v.wdata);
          checkOutput({name, " avm_byteenable"}, 32'(avm_byteenable), 32'(v.be));
        end
      end
    end
    checkOutput({name, " accept cycle"}, 32'(acc), 32'd1);
    @(posedge clk); #1;
    m_read[v.mst]  = 1'b0;
    m_write[v.mst] = 1'b0;
    if (v.rd && !v.wr) begin
      waitDrain(name);
    end else begin
      seen = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (m_readdatavalid != 2'b00) seen = 1'b1;
      end
      checkOutput({name, " no valid"}, 32'(seen), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int start, acc, acc0, acc1, vld, n, prev, first;

    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int start, acc, acc0, acc1, vld, n, prev, first;

    vecs[0] = '{0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{0, 1'b1, 1'b0, 5'd5, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b0, 1'b1, 5'd3, 32'h00000033, 4'hF, 32'h0};
    vecs[3] = '{1, 1'b0, 1'b1, 5'd5, 32'h12345678, 4'h3, 32'h0};
    vecs[4] = '{1, 1'b1, 1'b1, 5'd4, 32'h00000044, 4'hF, 32'h0};
    vecs[5] = '{0, 1'b1, 1'b0, 5'd4, 32'h0,        4'hF, 32'h00000044};
    vecs[6] = '{0, 1'b1, 1'b0, 5'd3, 32'h0,        4'hF, 32'h00000033};
    vecs[7] = '{1, 1'b1, 1'b0, 5'd5, 32'h0,        4'hF, 32'hDEAD5678};

    m_address = '0; m_writedata = '0; m_byteenable = '0; m_read = '0; m_write = '0;
    m3_address = '0; m3_writedata = '0; m3_byteenable = '0; m3_read = '0; m3_write = '0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset waitrequest", 32'(m_waitrequest), 32'h3);
    checkOutput("reset readdatavalid", 32'(m_readdatavalid), 32'h0);
    checkOutput("reset readdata", m_readdata[0] | m_readdata[1], 32'h0);
    checkOutput("reset avm cmd", {30'd0, avm_read, avm_write}, 32'h0);
    checkOutput("reset avm_address", avm_address, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Both masters write continuously: grants must alternate two cycles apart
    @(posedge clk); #1;
    m_address[0] = 32'd1; m_writedata[0] = 32'h11; m_byteenable[0] = 4'hF;
    m_address[1] = 32'd2; m_writedata[1] = 32'h22; m_byteenable[1] = 4'hF;
    m_write = 2'b11;
    n = 0; prev = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!m_waitrequest[i]) begin
          checkOutput($sformatf("alt grant %0d", n), 32'(i), 32'(n % 2));
          checkOutput($sformatf("alt address %0d", n), avm_address, (n % 2) ? 32'd2 : 32'd1);
          checkOutput($sformatf("alt data %0d", n), avm_writedata, (n % 2) ? 32'h22 : 32'h11);
          if (n > 0) checkOutput($sformatf("alt gap %0d", n), 32'(cyc - prev), 32'd2);
          prev = cyc;
          n++;
        end
      end
    end
    checkOutput("alt grant count", 32'(n), 32'd4);
    @(posedge clk); #1 m_write = 2'b00;

    // Simultaneous reads of addr 3: m0 first, m1 waits and keeps its old data meanwhile
    @(posedge clk); #1;
    m_address[0] = 32'd3; m_address[1] = 32'd3; m_read = 2'b11;
    start = cyc; acc0 = -1; acc1 = -1;
    sb_q.push_back('{mst: 0, data: 32'h33, due: start + 3});
    sb_q.push_back('{mst: 1, data: 32'h33, due: start + 6});
    for (int k = 0; k < 12 && acc1 < 0; k++) begin
      @(negedge clk);
      if (!m_waitrequest[0] && acc0 < 0) acc0 = cyc - start;
      if (!m_waitrequest[1]) acc1 = cyc - start;
      if (m_readdatavalid[0]) checkOutput("dual m1 readdata held", m_readdata[1], 32'hDEAD5678);
      @(posedge clk); #1;
      if (acc0 >= 0) m_read[0] = 1'b0;
      if (acc1 >= 0) m_read[1] = 1'b0;
    end
    checkOutput("dual m0 accept", 32'(acc0), 32'd1);
    checkOutput("dual m1 accept", 32'(acc1), 32'd4);
    waitDrain("dual");

    // Three-cycle slave latency on the second instance
    @(posedge clk); #1;
    m3_address[0] = 32'd7; m3_writedata[0] = 32'h77; m3_byteenable[0] = 4'hF; m3_write[0] = 1'b1;
    start = cyc; acc = -1;
    for (int k = 0; k < 10 && acc < 0; k++) begin
      @(negedge clk);
      if (!m3_waitrequest[0]) acc = cyc - start;
    end
    checkOutput("lat3 write accept", 32'(acc), 32'd1);
    @(posedge clk); #1;
    m3_write[0] = 1'b0; m3_read[0] = 1'b1;
    start = cyc; acc = -1; vld = -1;
    for (int k = 0; k < 12 && vld < 0; k++) begin
      @(negedge clk);
      if (!m3_waitrequest[0]) acc = cyc - start;
      if (m3_readdatavalid[0]) begin
        vld = cyc - start;
        checkOutput("lat3 read data", m3_readdata[0], 32'h77);
      end
      @(posedge clk); #1;
      if (acc >= 0) m3_read[0] = 1'b0;
    end
    checkOutput("lat3 read accept", 32'(acc), 32'd1);
    checkOutput("lat3 valid cycle", 32'(vld), 32'd5);

    // Reset during RD_WAIT aborts the read and restores the pointer
    applyStimulus('{1, 1'b0, 1'b1, 5'd9, 32'h99, 4'hF, 32'h0}, "pre-reset write");
    @(posedge clk); #1;
    m_address[1] = 32'd3; m_read[1] = 1'b1;
    acc = -1;
    for (int k = 0; k < 10 && acc < 0; k++) begin
      @(negedge clk);
      if (!m_waitrequest[1]) acc = 1;
    end
    checkOutput("abort read accepted", 32'(acc), 32'd1);
    @(posedge clk); #1;
    m_read[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort waitrequest", 32'(m_waitrequest), 32'h3);
    checkOutput("abort readdata cleared", m_readdata[1], 32'h0);
    checkOutput("abort avm_read", 32'(avm_read), 32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort no valid", 32'(m_readdatavalid), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_address[0] = 32'd10; m_writedata[0] = 32'hA0; m_byteenable[0] = 4'hF;
    m_address[1] = 32'd11; m_writedata[1] = 32'hB1; m_byteenable[1] = 4'hF;
    m_write = 2'b11;
    start = cyc; acc = -1; first = -1;
    for (int k = 0; k < 10 && acc < 0; k++) begin
      @(negedge clk);
      if (m_waitrequest != 2'b11) begin
        acc   = cyc - start;
        first = m_waitrequest[0] ? 1 : 0;
      end
    end
    checkOutput("post-reset first grant", 32'(first), 32'd0);
    checkOutput("post-reset accept cycle", 32'(acc), 32'd1);
    @(posedge clk); #1 m_write = 2'b00;
    repeat (4) @(negedge clk);

    checkOutput("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avmm_rr_arbiter.md
Name: avmm_rr_arbiter

Overview:
- Shares one Avalon-MM slave (the 32-word register memory: registered readdata, fixed read latency, no waitrequest/readdatavalid) between NUM_REQ Avalon-MM masters.
- Grants access round-robin and presents each master with a full pipelined-read interface (waitrequest, readdatavalid).
- Sits between the requesting masters and the memory slave.
- One transaction is outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- DATAWIDTH, 32, data width, same on both sides.
- ADDRESSWIDTH, 32, address width, passed through unchanged.
- READ_LATENCY, 1, slave cycles from the sampled read to valid avm_readdata (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- m_address  in  [NUM_REQ][ADDRESSWIDTH]  per-master address
- m_read  in  [NUM_REQ]  per-master read request
- m_write  in  [NUM_REQ]  per-master write request
- m_writedata  in  [NUM_REQ][DATAWIDTH]  per-master write data
- m_byteenable  in  [NUM_REQ][DATAWIDTH/8]  per-master byte enables
- m_waitrequest  out  [NUM_REQ]  low only in the cycle the master's command is accepted
- m_readdata  out  [NUM_REQ][DATAWIDTH]  registered read data
- m_readdatavalid  out  [NUM_REQ]  one-cycle pulse qualifying m_readdata
- avm_address  out  ADDRESSWIDTH  to slave
- avm_read  out  1  to slave
- avm_write  out  1  to slave
- avm_writedata  out  DATAWIDTH  to slave
- avm_byteenable  out  DATAWIDTH/8  to slave
- avm_readdata  in  DATAWIDTH  from slave

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset:
  - state=IDLE, m_waitrequest all 1, m_readdatavalid 0, m_readdata 0.
  - All avm_* outputs 0.
  - Round-robin pointer last_grant=NUM_REQ-1, so master 0 wins first.
- Request: master i requests when m_read[i] | m_write[i]. A master holds its command stable while m_waitrequest[i]=1 (Avalon rule; not checked).
- IDLE:
  - If any request is present, pick the winner as the first requester at or after index last_grant+1, modulo NUM_REQ.
  - Register grant_idx and the command type (write if m_write set, else read), then go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - avm_* driven combinationally from master grant_idx.
  - avm_write=m_write[g]; avm_read=m_read[g] & ~m_write[g].
  - m_waitrequest[g]=0, all others 1.
  - last_grant<=g.
  - Write: next state IDLE. Read: next state RD_WAIT with cnt<=READ_LATENCY-1.
- RD_WAIT:
  - avm_read=0; all m_waitrequest=1.
  - When cnt==0: m_readdata[g]<=avm_readdata, m_readdatavalid[g]<=1 for one cycle, next state IDLE.
  - Otherwise cnt decrements.
- Outside ISSUE, all avm_* outputs are 0.
- Latency from IDLE with the request present:
  - Write accepted at cycle +1.
  - Read accepted at +1; readdatavalid at +2+READ_LATENCY. With READ_LATENCY=1, acceptance is at cycle 1 and valid at cycle 3.
- Arbitration is fresh in every IDLE visit, with no back-to-back grants. A master that just won has lowest priority next.
- A lone requester is re-granted on every IDLE visit.
- Simultaneous read and write from one master (illegal): treated as a write. The read is dropped and no readdatavalid is produced.
- Requests that drop while waitrequest=1 are not sampled. Arbitration is combinational on current inputs.
- Reset mid-operation: an in-flight read is aborted, with no readdatavalid; the pointer resets.
- m_readdata[i] holds its last value until the next read for master i completes.

Decomposition:
- Package avmm_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} arb_state_t.
  - Function clog2-based index width helper.
- Sub-module rr_arbiter:
  - Parameters NUM_REQ.
  - Inputs req[NUM_REQ], last_grant, valid.
  - Outputs gnt_idx, gnt_any.
  - Combinational rotate-priority pick.
- The top holds the FSM, pointer, latency counter, muxes and read-data registers.

Test Plan:
- Reset, then master 0 writes addr 5 data 0xDEADBEEF, then reads addr 5:
  - Write: m_waitrequest[0] low at cycle 1; avm_write=1, avm_address=5.
  - Read: m_readdatavalid[0] pulses 3 cycles after the read's IDLE cycle with m_readdata[0]=0xDEADBEEF.
- Both masters continuously write (m0 addr 1 / 0x11, m1 addr 2 / 0x22): grants alternate 0,1,0,1; avm_address sequence 1,2,1,2; each acceptance 2 cycles apart.
- Both masters read addr 3 (preloaded with 0x33) at the same time: m0 gets valid 0x33 first; m1's waitrequest stays high until after m0's valid; m1 then gets 0x33; m1's m_readdata is never corrupted by m0's read.
- Master 1 asserts read and write together at addr 4 with data 0x44: write occurs, no readdatavalid; a later read of 4 returns 0x44.
- With READ_LATENCY=3 (slave model delayed), a read of addr 7 holding 0x77 gives valid 5 cycles after the IDLE cycle with 0x77.
- Assert rst_n=0 during RD_WAIT: no m_readdatavalid, m_waitrequest all 1. After release, master 0 wins first even if master 1 was last granted.
